// File: rtl/evm_pkg.sv
// Shared constants and types for the four-candidate voting machine datapath.
// Candidate indices double as the result-select encoding.
package evm_pkg;

  localparam int DEF_COUNT_W = 4;

  localparam logic [1:0] CAND_A = 2'd0;
  localparam logic [1:0] CAND_B = 2'd1;
  localparam logic [1:0] CAND_C = 2'd2;
  localparam logic [1:0] CAND_D = 2'd3;

  typedef logic [DEF_COUNT_W-1:0] count_t;

  // A ballot is valid only when exactly one button is pressed.
  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
  endfunction

endpackage

// File: rtl/vote_counter.sv
// Per-candidate tally: saturating up-counter with asynchronous active-low clear.
module vote_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX_CNT = {W{1'b1}};

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Increment only while below full scale so the tally never wraps.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != MAX_CNT)) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Tally register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/top.sv
// EVM core: strobe edge detector, one-hot ballot qualification, four tallies
// and a combinational result multiplexer.
module top
  import evm_pkg::*;
#(
  parameter int COUNT_W = DEF_COUNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               a,
  input  logic               b,
  input  logic               c,
  input  logic               d,
  input  logic               master_enable,
  input  logic [1:0]         s,
  output logic [COUNT_W-1:0] mux_out
);

  logic               me_q;
  logic               cast_s;
  logic [3:0]         btn_s;
  logic [3:0]         inc_s;
  logic [COUNT_W-1:0] cnt_s [4];

  // Previous strobe level; clearing it on reset makes a strobe that is
  // already high at release count as a fresh edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      me_q <= 1'b0;
    end else begin
      me_q <= master_enable;
    end
  end

  assign btn_s  = {d, c, b, a};
  assign cast_s = master_enable & ~me_q;

  // Route the cast to exactly one counter, or to none for an invalid ballot.
  always_comb begin
    inc_s = 4'b0000;
    if (cast_s && is_onehot4(btn_s)) begin
      inc_s = btn_s;
    end else begin
      inc_s = 4'b0000;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_cnt
    vote_counter #(.W(COUNT_W)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (inc_s[g]),
      .count (cnt_s[g])
    );
  end

  // Result select straight from the tally registers.
  always_comb begin
    mux_out = '0;
    case (s)
      CAND_A:  mux_out = cnt_s[0];
      CAND_B:  mux_out = cnt_s[1];
      CAND_C:  mux_out = cnt_s[2];
      CAND_D:  mux_out = cnt_s[3];
      default: mux_out = '0;
    endcase
  end

endmodule

// File: tb/tb_top.sv
// Directed bench for the EVM core; expectations are queued by the stimulus
// and compared against mux_out by an independent monitor.
module tb_top;
  import evm_pkg::*;

  logic       clk;
  logic       reset;
  logic       a, b, c, d;
  logic       master_enable;
  logic [1:0] s;
  count_t     mux_out;

  int checks = 0;
  int errors = 0;

  int    exp_q  [$];
  string name_q [$];
  event  chk_ev;

  top #(.COUNT_W(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .a             (a),
    .b             (b),
    .c             (c),
    .d             (d),
    .master_enable (master_enable),
    .s             (s),
    .mux_out       (mux_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: each time the stimulus presents a select, compare with the queue head.
  initial begin
    forever begin
      @(chk_ev);
      if (exp_q.size() > 0) begin
        int    e;
        string n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        checks++;
        if (int'(mux_out) != e) begin
          errors++;
          $display("FAIL %s: mux_out=%0d expected=%0d (s=%0d)", n, mux_out, e, s);
        end
      end
    end
  end

  task automatic expect_sel(input logic [1:0] sel, input int e, input string n);
    s = sel;
    exp_q.push_back(e);
    name_q.push_back(n);
    #1;
    -> chk_ev;
    #0;
  endtask

  task automatic expect_all(input int ea, input int eb, input int ec, input int ed,
                            input string n);
    expect_sel(CAND_A, ea, {n, "_a"});
    expect_sel(CAND_B, eb, {n, "_b"});
    expect_sel(CAND_C, ec, {n, "_c"});
    expect_sel(CAND_D, ed, {n, "_d"});
  endtask

  // One strobe: buttons and strobe raised at a negedge, held for hold cycles.
  task automatic vote(input logic [3:0] btn, input int hold);
    @(negedge clk);
    {d, c, b, a} = btn;
    master_enable = 1'b1;
    repeat (hold) @(negedge clk);
    master_enable = 1'b0;
    {d, c, b, a} = 4'b0000;
    @(negedge clk);
  endtask

  logic [3:0] seq [15];

  initial begin
    seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0100, 4'b1000, 4'b0001,
            4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100};
    reset = 1'b0;
    master_enable = 1'b0;
    {d, c, b, a} = 4'b0000;
    s = 2'd0;

    // Asynchronous reset: tallies visible as zero before any clock edge.
    #1;
    expect_all(0, 0, 0, 0, "reset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Mixed ballot sequence with 1- and 2-cycle strobes.
    for (int i = 0; i < 15; i++) vote(seq[i], (i % 2) + 1);
    expect_all(7, 2, 3, 3, "seq");

    // Strobe held for 10 cycles; mid-hold button change is ignored.
    @(negedge clk);
    a = 1'b1;
    master_enable = 1'b1;
    repeat (5) @(negedge clk);
    a = 1'b0;
    b = 1'b1;
    repeat (5) @(negedge clk);
    master_enable = 1'b0;
    b = 1'b0;
    @(negedge clk);
    expect_all(8, 2, 3, 3, "held");

    // Invalid ballots: two buttons, then none.
    vote(4'b0011, 1);
    vote(4'b0000, 2);
    expect_all(8, 2, 3, 3, "invalid");

    // Saturation on candidate d.
    for (int i = 0; i < 20; i++) vote(4'b1000, 1);
    expect_sel(CAND_D, 15, "sat");
    vote(4'b1000, 1);
    expect_sel(CAND_D, 15, "sat_hold");
    expect_sel(CAND_A, 8, "sat_a_untouched");

    // Reset asserted mid-strobe clears immediately.
    @(negedge clk);
    a = 1'b1;
    master_enable = 1'b1;
    #2;
    reset = 1'b0;
    expect_all(0, 0, 0, 0, "midreset");
    // Strobe still high at release counts as one vote, held strobe adds none.
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    master_enable = 1'b0;
    a = 1'b0;
    @(negedge clk);
    expect_sel(CAND_A, 1, "release_edge");

    // Fresh vote for b after the reset.
    @(negedge clk);
    reset = 1'b0;
    #1;
    expect_sel(CAND_A, 0, "pulse_clear");
    @(negedge clk);
    reset = 1'b1;
    vote(4'b0010, 1);
    expect_sel(CAND_B, 1, "post_reset_b");
    expect_sel(CAND_C, 0, "post_reset_c");

    // Bounded drain of the expectation queue.
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
